// File: rtl/ser_sched_pkg.sv
// Shared types for the serializer scheduler.
package ser_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StWait   = 2'd2
  } state_e;

endpackage

// File: rtl/serializer_scheduler_if.sv
// Handshake/qualifier bundle between upstream, scheduler and downstream.
// Optional abort input is present when SER_SCHED_ABORT_EN is defined.
interface serializer_scheduler_if #(
  parameter int unsigned INPUT_SIZE = 8,
  parameter int unsigned PASS_W     = 8
);
  localparam int unsigned IDX_W = $clog2(INPUT_SIZE);

  logic              vec_valid;
  logic              vec_ready;
  logic [PASS_W-1:0] num_passes;
  logic              pass_ready;
  logic              ser_update;
  logic              ser_valid;
  logic [IDX_W-1:0]  ser_index;
  logic              ser_first;
  logic              ser_last;
  logic [PASS_W-1:0] pass_idx;
  logic              done;
  logic              busy;
`ifdef SER_SCHED_ABORT_EN
  logic              abort;

  modport master (
    output vec_valid, num_passes, pass_ready, abort,
    input  vec_ready, ser_update, ser_valid, ser_index, ser_first, ser_last,
    input  pass_idx, done, busy
  );

  modport slave (
    input  vec_valid, num_passes, pass_ready, abort,
    output vec_ready, ser_update, ser_valid, ser_index, ser_first, ser_last,
    output pass_idx, done, busy
  );
`else
  modport master (
    output vec_valid, num_passes, pass_ready,
    input  vec_ready, ser_update, ser_valid, ser_index, ser_first, ser_last,
    input  pass_idx, done, busy
  );

  modport slave (
    input  vec_valid, num_passes, pass_ready,
    output vec_ready, ser_update, ser_valid, ser_index, ser_first, ser_last,
    output pass_idx, done, busy
  );
`endif

endinterface

// File: rtl/mod_counter.sv
// Wrap counter: counts 0..Modulus-1 while enabled; clr has priority over en.
module mod_counter #(
  parameter int unsigned Modulus = 8,
  parameter int unsigned Width   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MaxCount = Width'(Modulus - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == MaxCount) ? '0 : count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serializer_scheduler.sv
// Sequences a rotating Serializer: one load per vector, replayed for N passes.
// Define SER_SCHED_ABORT_EN to add an abort input that drops the current job.
module serializer_scheduler
  import ser_sched_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 8,
  parameter int unsigned PASS_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  serializer_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(INPUT_SIZE);
  localparam logic [IDX_W-1:0] LastPhase = IDX_W'(INPUT_SIZE - 1);

  state_e            state_q, state_d;
  logic [PASS_W-1:0] pass_idx_q, pass_idx_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  phase;
  logic              phase_last;
  logic              final_beat;
  logic              accept;
  logic              abort_req;

`ifdef SER_SCHED_ABORT_EN
  assign abort_req = bus.abort & (state_q != StIdle);
`else
  assign abort_req = 1'b0;
`endif

  assign phase_last = (phase == LastPhase);
  assign final_beat = (state_q == StStream) & phase_last &
                      (pass_idx_q == passes_q - PASS_W'(1));

  // A new vector may only land where the serializer is free to be reloaded.
  assign bus.vec_ready  = ~rst & ~abort_req & bus.pass_ready &
                          ((state_q == StIdle) | final_beat);
  assign accept         = bus.vec_valid & bus.vec_ready;
  assign bus.ser_update = accept;

  // Phase mirrors the serializer rotation, so it must keep running through bubbles.
  mod_counter #(
    .Modulus (INPUT_SIZE),
    .Width   (IDX_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (state_q != StIdle),
    .count (phase)
  );

  always_comb begin
    state_d    = state_q;
    pass_idx_d = pass_idx_q;
    passes_d   = passes_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StIdle;
      end
      StStream: begin
        if (phase_last) begin
          if (final_beat) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pass_idx_d = pass_idx_q + PASS_W'(1);
            state_d    = bus.pass_ready ? StStream : StWait;
          end
        end
      end
      StWait: begin
        if (phase_last && bus.pass_ready) begin
          state_d = StStream;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d    = StStream;
      pass_idx_d = '0;
      passes_d   = (bus.num_passes == '0) ? PASS_W'(1) : bus.num_passes;
    end

    if (abort_req) begin
      state_d    = StIdle;
      pass_idx_d = pass_idx_q;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pass_idx_q <= '0;
      passes_q   <= PASS_W'(1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pass_idx_q <= pass_idx_d;
      passes_q   <= passes_d;
      done_q     <= done_d;
    end
  end

  assign bus.ser_valid = (state_q == StStream);
  assign bus.ser_index = phase;
  assign bus.ser_first = bus.ser_valid & (phase == '0);
  assign bus.ser_last  = bus.ser_valid & phase_last;
  assign bus.pass_idx  = pass_idx_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serializer_scheduler.sv
// Self-checking bench: randomized job timeline predicted from pass/bubble arithmetic.
module tb_serializer_scheduler;

  localparam int unsigned N     = 4;
  localparam int unsigned PW    = 8;
  localparam int          MaxC  = 2048;
  localparam int          NJobs = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serializer_scheduler_if #(.INPUT_SIZE(N), .PASS_W(PW)) bus ();

  serializer_scheduler #(.INPUT_SIZE(N), .PASS_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural rotating serializer: load on update, else rotate toward element 0.
  logic [7:0] data_in [N];
  logic [7:0] ser_reg [N];
  always @(posedge clk) begin
    if (bus.ser_update) begin
      for (int i = 0; i < N; i++) ser_reg[i] <= data_in[i];
    end else begin
      for (int i = 0; i < N - 1; i++) ser_reg[i] <= ser_reg[i + 1];
      ser_reg[N - 1] <= ser_reg[0];
    end
  end

  // Stimulus schedule and expected timeline, one entry per cycle.
  bit          vv_a    [MaxC];
  bit          pr_a    [MaxC];
  logic [PW-1:0] np_a  [MaxC];
  int          jid_a   [MaxC];
  bit          e_upd   [MaxC];
  bit          e_valid [MaxC];
  bit          e_done  [MaxC];
  bit          e_busy  [MaxC];
  bit          e_final [MaxC];
  int          e_idx   [MaxC];
  int          e_pass  [MaxC];
  logic [7:0]  e_elem  [MaxC];
  logic [7:0]  vecs    [NJobs + 2][N];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_data(input int j);
    for (int i = 0; i < N; i++) data_in[i] = vecs[j][i];
  endtask

  initial begin
    int prev_f, prev_a, a, f, eff, p, g, rise, e, cnt, t_end, done_at;
    bit b2b;
    int bub [8];
    int starts [8];

    for (int c = 0; c < MaxC; c++) begin
      pr_a[c] = 1'($urandom_range(0, 1));
      vv_a[c] = 1'b0; np_a[c] = '0; jid_a[c] = 0;
      e_upd[c] = 0; e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0; e_final[c] = 0;
      e_idx[c] = 0; e_pass[c] = 0; e_elem[c] = '0;
    end
    for (int j = 0; j < NJobs + 2; j++)
      for (int i = 0; i < N; i++) vecs[j][i] = 8'($urandom_range(0, 255));

    prev_f = -1;
    prev_a = -1;
    for (int j = 0; j < NJobs; j++) begin
      p   = $urandom_range(0, 4);
      b2b = ($urandom_range(0, 2) == 0) && (j > 0);
      g   = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) bub[k] = $urandom_range(0, 2);
      if (j == 0) begin p = 1; b2b = 0; g = 1; end
      if (j == 1) begin p = 3; b2b = 0; g = 2; bub[1] = 0; bub[2] = 0; end
      if (j == 2) begin p = 2; b2b = 0; bub[1] = 2; end
      if (j == 3) begin p = 1; b2b = 1; end
      if (j == 4) begin p = 0; b2b = 0; end
      eff = (p == 0) ? 1 : p;

      if (b2b) begin
        a    = prev_f;
        rise = a - $urandom_range(0, 3);
        if (rise <= prev_a) rise = prev_a + 1;
      end else begin
        a    = prev_f + g;
        rise = $urandom_range(prev_f + 1, a);
      end
      for (int c = rise; c <= a; c++) begin
        vv_a[c] = 1'b1; np_a[c] = PW'(p); jid_a[c] = j;
        if (c < a && !b2b) pr_a[c] = 1'b0;
      end
      pr_a[a]  = 1'b1;
      e_upd[a] = 1'b1;

      starts[0] = a + 1;
      for (int k = 1; k < eff; k++) begin
        e = starts[k - 1] + N - 1;
        if (bub[k] == 0) begin
          pr_a[e] = 1'b1;
        end else begin
          pr_a[e] = 1'b0;
          for (int r = 1; r <= bub[k]; r++) pr_a[e + N * r] = (r == bub[k]);
        end
        starts[k] = starts[k - 1] + N * (1 + bub[k]);
      end
      f = starts[eff - 1] + N - 1;

      for (int k = 0; k < eff; k++)
        for (int i = 0; i < N; i++) begin
          e_valid[starts[k] + i] = 1'b1;
          e_idx[starts[k] + i]   = i;
          e_elem[starts[k] + i]  = vecs[j][i];
        end
      for (int c = a + 1; c <= f; c++) e_busy[c] = 1'b1;
      e_final[f]    = 1'b1;
      e_done[f + 1] = 1'b1;
      for (int c = a + 1; c < MaxC; c++) begin
        cnt = 0;
        for (int k = 1; k < eff; k++) if (starts[k - 1] + N <= c) cnt++;
        e_pass[c] = cnt;
      end
      prev_a = a;
      prev_f = f;
    end
    t_end = prev_f + 6;

    // Reset: handshake outputs held low even with a vector offered.
    rst = 1'b1;
    bus.vec_valid = 1'b1; bus.pass_ready = 1'b1; bus.num_passes = PW'(3);
`ifdef SER_SCHED_ABORT_EN
    bus.abort = 1'b0;
`endif
    load_data(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_vec_ready", -1, 32'(bus.vec_ready), 0);
    check("rst_ser_update", -1, 32'(bus.ser_update), 0);
    step();
    rst = 1'b0; bus.vec_valid = 1'b0;
    @(negedge clk);
    check("rst_busy", -1, 32'(bus.busy), 0);
    check("rst_valid", -1, 32'(bus.ser_valid), 0);
    check("rst_done", -1, 32'(bus.done), 0);
    check("rst_pass_idx", -1, 32'(bus.pass_idx), 0);

    for (int c = 0; c < t_end; c++) begin
      step();
      bus.vec_valid  = vv_a[c];
      bus.pass_ready = pr_a[c];
      bus.num_passes = np_a[c];
      load_data(jid_a[c]);
      @(negedge clk);
      check("vec_ready", c, 32'(bus.vec_ready),
            32'(pr_a[c] & (~e_busy[c] | e_final[c])));
      check("ser_update", c, 32'(bus.ser_update), 32'(e_upd[c]));
      check("ser_valid", c, 32'(bus.ser_valid), 32'(e_valid[c]));
      check("ser_first", c, 32'(bus.ser_first), 32'(e_valid[c] && e_idx[c] == 0));
      check("ser_last", c, 32'(bus.ser_last), 32'(e_valid[c] && e_idx[c] == N - 1));
      check("done", c, 32'(bus.done), 32'(e_done[c]));
      check("busy", c, 32'(bus.busy), 32'(e_busy[c]));
      check("pass_idx", c, 32'(bus.pass_idx), 32'(e_pass[c]));
      if (e_valid[c]) begin
        check("ser_index", c, 32'(bus.ser_index), 32'(e_idx[c]));
        check("element", c, 32'(ser_reg[0]), 32'(e_elem[c]));
      end
    end

    // Reset in the middle of a single-pass job.
    step();
    bus.vec_valid = 1'b1; bus.pass_ready = 1'b1; bus.num_passes = PW'(1);
    load_data(NJobs);
    @(negedge clk);
    check("mid_rst_accept", 0, 32'(bus.ser_update), 1);
    step();
    bus.vec_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_beat0", 1, 32'(ser_reg[0]), 32'(vecs[NJobs][0]));
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_index2", 3, 32'(bus.ser_index), 2);
    check("mid_rst_ready", 3, 32'(bus.vec_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 4, 32'(bus.ser_valid), 0);
    check("mid_rst_busy", 4, 32'(bus.busy), 0);
    check("mid_rst_pass", 4, 32'(bus.pass_idx), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_done", 4 + k, 32'(bus.done), 0);
      step();
    end

`ifdef SER_SCHED_ABORT_EN
    // Abort while waiting for a bubble rotation, then start a fresh job.
    step();
    bus.vec_valid = 1'b1; bus.pass_ready = 1'b1; bus.num_passes = PW'(2);
    load_data(NJobs);
    @(negedge clk);
    check("abort_accept1", 0, 32'(bus.ser_update), 1);
    step();
    bus.vec_valid = 1'b0; bus.pass_ready = 1'b0;
    step(); step(); step();
    step();
    @(negedge clk);
    check("abort_in_wait", 5, 32'(bus.busy && !bus.ser_valid), 1);
    step();
    bus.abort = 1'b1; bus.vec_valid = 1'b1; bus.pass_ready = 1'b1;
    load_data(NJobs + 1);
    @(negedge clk);
    check("abort_ready", 6, 32'(bus.vec_ready), 0);
    step();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 7, 32'(bus.busy), 0);
    check("abort_no_done", 7, 32'(bus.done), 0);
    check("abort_reaccept", 7, 32'(bus.ser_update), 1);
    step();
    bus.vec_valid = 1'b0;
    @(negedge clk);
    check("abort_new_first", 8, 32'(bus.ser_first), 1);
    check("abort_new_elem", 8, 32'(ser_reg[0]), 32'(vecs[NJobs + 1][0]));
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      @(negedge clk);
      if (bus.done && done_at < 0) done_at = k;
    end
    check("abort_new_done_at", 8, 32'(done_at), 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_scheduler.md
Name: serializer_scheduler

Overview:
Sequences one Serializer instance for the MAC datapath. Accepts a parallel input vector from upstream, pulses the serializer load, and emits per-beat valid/index/first/last qualifiers. Replays the same vector for NUM passes (one per output neuron) by exploiting the serializer's INPUT_SIZE-cycle rotation wrap, without reloading. Inserts whole-rotation bubbles when downstream is not ready at a pass boundary.

Parameters:
INPUT_SIZE, 8, elements per vector; must match the Serializer; minimum 2
PASS_W, 8, width of the pass-count configuration

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
vec_valid  in  1  upstream vector (serializer data_in) valid; held with data until accepted
vec_ready  out  1  scheduler accepts vector this cycle
num_passes  in  PASS_W  pass count, sampled on accept; 0 treated as 1
pass_ready  in  1  downstream can take a full pass starting next cycle
ser_update  out  1  to Serializer serializer_update
ser_valid  out  1  serial_out carries a valid element this cycle
ser_index  out  $clog2(INPUT_SIZE)  element index of serial_out
ser_first  out  1  ser_valid and index 0
ser_last  out  1  ser_valid and index INPUT_SIZE-1
pass_idx  out  PASS_W  current pass number, 0-based
done  out  1  one-cycle pulse after final beat of final pass
busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous: state IDLE, phase 0, pass_idx 0. ser_valid, done and busy are 0. vec_ready and ser_update are 0 while rst is high.
- States: IDLE, STREAM, WAIT.
- Accept = vec_valid & vec_ready; ser_update = accept (combinational, same cycle).
  - Serializer registers data at that edge; element 0 appears on serial_out the next cycle.
- vec_ready = pass_ready & (IDLE or final_beat); final_beat = STREAM & phase==INPUT_SIZE-1 & pass_idx==passes-1.
- On accept:
  - latch passes = max(num_passes,1), phase <= 0, pass_idx <= 0, state <= STREAM.
  - Latency: accept to first ser_valid is 1 cycle.
- phase is a free-running mod-INPUT_SIZE counter in STREAM and WAIT; it tracks serializer rotation, so serial_out = element[phase].
- STREAM: ser_valid=1, ser_index=phase. At phase==INPUT_SIZE-1:
  - final pass, with accept (back-to-back): reload, stay STREAM, pass_idx <= 0, phase <= 0. No bubble.
  - final pass, no accept: go IDLE, done <= 1 next cycle.
  - more passes, pass_ready=1: pass_idx++, stay STREAM (continuous).
  - more passes, pass_ready=0: go WAIT, pass_idx++.
- WAIT: ser_valid=0, phase keeps counting. At phase==INPUT_SIZE-1 with pass_ready=1, go STREAM; otherwise stay WAIT for another full rotation. Bubbles are always a multiple of INPUT_SIZE cycles.
- pass_ready is sampled only at phase==INPUT_SIZE-1, or in IDLE via vec_ready.
- done is registered: high exactly one cycle, the cycle after the final beat, including the back-to-back case.
- Reset mid-stream: IDLE on the next edge. Serializer contents are don't-care; no done pulse.

Optional Feature:
SER_SCHED_ABORT_EN:
- Defined: adds input abort (1 bit). abort=1 in STREAM or WAIT forces IDLE next edge and clears ser_valid next cycle; no done pulse; vec_ready=0 that cycle. abort in IDLE has no effect.
- Undefined: no abort port; the only way to leave a job early is rst.

Decomposition:
- Package ser_sched_pkg: state enum (IDLE, STREAM, WAIT); IDX_W = $clog2(INPUT_SIZE) computed in-module from the parameter.
- Sub-module mod_counter, a wrap counter with enable, used for phase.

Test Plan:
- INPUT_SIZE=4, num_passes=1, pass_ready=1, accept at cycle 0 -> ser_update at 0; ser_valid cycles 1-4, index 0,1,2,3; ser_first at 1; ser_last at 4; done at 5; Serializer output matches vector.
- num_passes=3, pass_ready=1 -> 12 contiguous valid beats; pass_idx 0,1,2 changing after each ser_last; element sequence repeats; done once.
- num_passes=2, pass_ready=0 at the first ser_last and held low 6 cycles -> exactly 8 bubble cycles (2 rotations) before pass 1; index restarts at 0 with correct element.
- Back-to-back: second vec_valid waiting during the last pass -> accept on the final_beat cycle; next cycle index 0 of the new vector; done pulses once for job 1.
- num_passes=0 -> behaves as 1 pass. rst asserted at beat 2 -> IDLE next cycle, ser_valid=0, no done.
- SER_SCHED_ABORT_EN: abort during WAIT -> IDLE next cycle, no done; a fresh vector is then accepted normally.
